// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM encoding,
// requester identifiers and default bus widths.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;
    localparam int LAT_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } arb_state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_IO  = 1'b1;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Two-way round-robin winner select, purely combinational (zero latency).
// No backpressure: on a tie the requester that did not win last time is picked.
module mem_arb_rr_pick
    import mem_arb_pkg::*;
(
    input  logic i_cpu_req,
    input  logic i_io_req,
    input  logic i_last_gnt,
    output logic o_grant,
    output logic o_winner
);

    always_comb begin
        o_grant  = i_cpu_req | i_io_req;
        o_winner = REQ_CPU;
        if (i_cpu_req && i_io_req) begin
            o_winner = ~i_last_gnt;
        end else if (i_io_req) begin
            o_winner = REQ_IO;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between CPU and I/O; write done at T+2, read at T+2+MEM_LAT.
// One transaction in flight; losers simply hold req, and cpu_stall freezes the CPU until its done pulse.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MEM_LAT = 1
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              io_req,
    input  logic              io_we,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic              io_done,
    output logic [DATA_W-1:0] io_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              r_owner;
    logic              r_last_gnt;
    logic              r_we;
    logic [LAT_W-1:0]  r_lat_cnt;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_io_rdata;

    logic              w_grant;
    logic              w_winner;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    mem_arb_rr_pick u_rr_pick (
        .i_cpu_req  (cpu_req),
        .i_io_req   (io_req),
        .i_last_gnt (r_last_gnt),
        .o_grant    (w_grant),
        .o_winner   (w_winner)
    );

    assign w_sel_we    = (w_winner == REQ_IO) ? io_we    : cpu_we;
    assign w_sel_addr  = (w_winner == REQ_IO) ? io_addr  : cpu_addr;
    assign w_sel_wdata = (w_winner == REQ_IO) ? io_wdata : cpu_wdata;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_grant) w_state_nxt = ST_ACCESS;
            ST_ACCESS: w_state_nxt = r_we ? ST_DONE : ST_WAIT;
            ST_WAIT:   if (r_lat_cnt == LAT_W'(1)) w_state_nxt = ST_DONE;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // The memory strobe is launched at the grant edge so it appears exactly in ACCESS.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_owner     <= REQ_CPU;
            r_last_gnt  <= REQ_IO;
            r_we        <= 1'b0;
            r_lat_cnt   <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_rdata <= '0;
            r_io_rdata  <= '0;
        end else begin
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_owner     <= w_winner;
                        r_last_gnt  <= w_winner;
                        r_we        <= w_sel_we;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= w_sel_we;
                        r_mem_addr  <= w_sel_addr;
                        r_mem_wdata <= w_sel_wdata;
                    end
                end
                ST_ACCESS: begin
                    if (!r_we) r_lat_cnt <= LAT_W'(MEM_LAT);
                end
                ST_WAIT: begin
                    r_lat_cnt <= r_lat_cnt - LAT_W'(1);
                    if (r_lat_cnt == LAT_W'(1)) begin
                        if (r_owner == REQ_IO) r_io_rdata  <= mem_rdata;
                        else                   r_cpu_rdata <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cpu_done  = (r_state == ST_DONE) && (r_owner == REQ_CPU);
    assign io_done   = (r_state == ST_DONE) && (r_owner == REQ_IO);
    assign cpu_stall = cpu_req & ~cpu_done;
    assign cpu_rdata = r_cpu_rdata;
    assign io_rdata  = r_io_rdata;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a latency-accurate memory model.
// Drivers push expected transactions; a negedge monitor checks every access and done pulse.
module tb_mem_port_arbiter;

    localparam int LAT = 4;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0, cpu_wdata = '0;
    logic        cpu_done, cpu_stall;
    logic [15:0] cpu_rdata;
    logic        io_req = 1'b0, io_we = 1'b0;
    logic [15:0] io_addr = '0, io_wdata = '0;
    logic        io_done;
    logic [15:0] io_rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) dut (
        .CLK(CLK), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_done(io_done), .io_rdata(io_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h5A5A);
    endfunction

    // Memory environment: data appears on mem_rdata only in cycle mem_en + LAT.
    logic [15:0] env_mem [65536];
    bit          env_wr  [65536];
    logic [LAT-1:0] pv = '0;
    logic [15:0] pd [LAT];

    always @(posedge CLK) begin
        if (mem_en && mem_we) begin
            env_mem[mem_addr] <= mem_wdata;
            env_wr[mem_addr]  <= 1'b1;
        end
        pv    <= {pv[LAT-2:0], mem_en & ~mem_we};
        pd[0] <= env_wr[mem_addr] ? env_mem[mem_addr] : init_val(mem_addr);
        for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
    end
    assign mem_rdata = pv[LAT-1] ? pd[LAT-1] : 16'hDEAD;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } txn_t;

    txn_t        q0[$];
    txn_t        q1[$];
    logic [15:0] ref_mem [logic [15:0]];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic        last_w = 1'b1;
    logic        inflight = 1'b0;
    logic        inflight_own = 1'b0;
    int          acc_cyc = 0;
    bit          acc_seen [2];
    logic [15:0] exp_rd [2];
    logic        prev_cpu_req = 1'b0, prev_io_req = 1'b0;
    int          gnt_log[$];
    logic        mw;
    txn_t        mt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    task automatic done_chk(input bit r);
        txn_t t;
        if (!inflight || inflight_own != r || (r ? q1.size() : q0.size()) == 0) begin
            fail(r ? "io_done_unexpected" : "cpu_done_unexpected");
        end else begin
            t = r ? q1.pop_front() : q0.pop_front();
            chk("done_latency", cyc - acc_cyc, t.we ? 1 : 1 + LAT);
            if (!t.we) begin
                chk(r ? "io_rdata" : "cpu_rdata", r ? io_rdata : cpu_rdata, t.rdata);
                exp_rd[r] = t.rdata;
            end
            chk("other_rdata_held", r ? cpu_rdata : io_rdata, exp_rd[~r]);
            inflight = 1'b0;
        end
    endtask

    always @(negedge CLK) begin
        cyc++;
        if (Reset) begin
            q0.delete();
            q1.delete();
            inflight  = 1'b0;
            last_w    = 1'b1;
            exp_rd[0] = '0;
            exp_rd[1] = '0;
        end else begin
            chk("cpu_stall", cpu_stall, cpu_req & ~cpu_done);
            if (mem_en) begin
                if (!prev_cpu_req && !prev_io_req) begin
                    fail("access_without_request");
                end else begin
                    mw = (prev_cpu_req && prev_io_req) ? ~last_w : prev_io_req;
                    chk("access_overlap", inflight, 1'b0);
                    if ((mw ? q1.size() : q0.size()) == 0) begin
                        fail("access_without_txn");
                    end else begin
                        mt = mw ? q1[0] : q0[0];
                        chk("mem_we", mem_we, mt.we);
                        chk("mem_addr", mem_addr, mt.addr);
                        if (mt.we) chk("mem_wdata", mem_wdata, mt.wdata);
                    end
                    last_w       = mw;
                    inflight     = 1'b1;
                    inflight_own = mw;
                    acc_cyc      = cyc;
                    acc_seen[mw] = 1'b1;
                    gnt_log.push_back(int'(mw));
                end
            end
            if (cpu_done) done_chk(1'b0);
            if (io_done)  done_chk(1'b1);
        end
        prev_cpu_req = cpu_req;
        prev_io_req  = io_req;
    end

    task automatic issue(input bit r, input logic we, input logic [15:0] a, input logic [15:0] d);
        txn_t t;
        @(posedge CLK);
        #1;
        t.we    = we;
        t.addr  = a;
        t.wdata = d;
        t.rdata = ref_mem.exists(a) ? ref_mem[a] : init_val(a);
        if (we) ref_mem[a] = d;
        if (r) q1.push_back(t); else q0.push_back(t);
        acc_seen[r] = 1'b0;
        if (r) begin io_req = 1'b1;  io_we = we;  io_addr = a;  io_wdata = d;  end
        else   begin cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
    endtask

    task automatic scramble(input bit r, input bit fixed);
        logic [15:0] v;
        v = fixed ? 16'h0FFF : 16'($urandom);
        if (r) begin io_addr = v;  io_wdata = v;  if (!fixed) io_we = ~io_we;   end
        else   begin cpu_addr = v; cpu_wdata = v; if (!fixed) cpu_we = ~cpu_we; end
    endtask

    task automatic wait_done(input bit r, input bit scr);
        bit got;
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge CLK);
            got = r ? io_done : cpu_done;
            if (!got) begin
                @(posedge CLK);
                #1;
                if (scr && n == 0)    scramble(r, 1'b1);
                else if (acc_seen[r]) scramble(r, 1'b0);
            end
        end
        if (!got) fail(r ? "io_done_timeout" : "cpu_done_timeout");
        @(posedge CLK);
        #1;
        if (r) io_req = 1'b0; else cpu_req = 1'b0;
    endtask

    task automatic txn(input bit r, input logic we, input logic [15:0] a,
                       input logic [15:0] d, input bit scr);
        issue(r, we, a, d);
        wait_done(r, scr);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge CLK);
        #1 Reset = 1'b0;
        @(negedge CLK);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 16'h0);
        chk("rst_mem_wdata", mem_wdata, 16'h0);
        chk("rst_done", {cpu_done, io_done}, 2'b00);
        chk("rst_cpu_rdata", cpu_rdata, 16'h0);
        chk("rst_io_rdata", io_rdata, 16'h0);

        // CPU read alone; inputs change to 0x0FFF in the ACCESS cycle
        txn(1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1);
        chk("cpu_read_beef", cpu_rdata, 16'hBEEF);
        // I/O write alone
        txn(1'b1, 1'b1, 16'h0200, 16'h1234, 1'b0);

        // Simultaneous requests must alternate starting with the CPU
        gnt_log.delete();
        for (int i = 0; i < 4; i++) begin
            fork
                txn(1'b0, i[0],  16'h0040 + 16'(i), 16'hC000 + 16'(i), 1'b0);
                txn(1'b1, ~i[0], 16'h0200 + 16'(i), 16'hA000 + 16'(i), 1'b0);
            join
        end
        chk("rr_count", gnt_log.size(), 8);
        for (int i = 0; i < 8 && i < gnt_log.size(); i++) chk("rr_order", gnt_log[i], i % 2);

        // Reset while a CPU read is waiting on memory
        issue(1'b0, 1'b0, 16'h0020, 16'h0000);
        begin
            bit seen;
            seen = 1'b0;
            for (int n = 0; n < 50 && !seen; n++) begin
                @(posedge CLK);
                #1;
                seen = acc_seen[0];
            end
            if (!seen) fail("reset_test_no_access");
        end
        chk("busy_before_reset", busy, 1'b1);
        Reset   = 1'b1;
        cpu_req = 1'b0;
        @(posedge CLK);
        #1 Reset = 1'b0;
        @(negedge CLK);
        chk("wrst_busy", busy, 1'b0);
        chk("wrst_mem_en", mem_en, 1'b0);
        chk("wrst_cpu_rdata", cpu_rdata, 16'h0);
        chk("wrst_io_rdata", io_rdata, 16'h0);
        chk("wrst_done", {cpu_done, io_done}, 2'b00);
        repeat (8) @(negedge CLK);
        txn(1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0);

        // Randomized concurrent traffic on disjoint address regions
        fork
            for (int k = 0; k < 40; k++) begin
                repeat ($urandom_range(0, 3)) @(posedge CLK);
                txn(1'b0, 1'($urandom), {8'h00, 8'($urandom)}, 16'($urandom), 1'b0);
            end
            for (int k = 0; k < 40; k++) begin
                repeat ($urandom_range(0, 3)) @(posedge CLK);
                txn(1'b1, 1'($urandom), {8'h80, 8'($urandom)}, 16'($urandom), 1'b0);
            end
        join

        repeat (5) @(negedge CLK);
        chk("cpu_queue_drained", q0.size(), 0);
        chk("io_queue_drained", q1.size(), 0);
        chk("nothing_in_flight", inflight, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory between two requesters.
- Requester 0 is the multi-cycle CPU control/datapath, which issues fetch, LW and SW accesses.
- Requester 1 is the I/O / SYSCALL-service DMA port.
- Round-robin arbitration, one transaction in flight at a time, fixed memory read latency.
- cpu_stall holds the control-unit FSM in its current state until its access completes.

Parameters:
ADDR_W, 16, address width (word address)
DATA_W, 16, data width
MEM_LAT, 1, memory read latency in cycles from mem_en to valid mem_rdata; legal range 1..15

Ports:
CLK  in  1  clock, all state on rising edge
Reset  in  1  synchronous, active-high reset
cpu_req  in  1  CPU access request; held until cpu_done
cpu_we  in  1  1 = write (SW), 0 = read (fetch/LW)
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_done  out  1  one-cycle completion pulse to CPU
cpu_rdata  out  DATA_W  registered read data, valid while cpu_done=1
cpu_stall  out  1  cpu_req & ~cpu_done (combinational); freezes control-unit state register
io_req  in  1  I/O requester request; held until io_done
io_we  in  1  I/O write enable
io_addr  in  ADDR_W  I/O address
io_wdata  in  DATA_W  I/O write data
io_done  out  1  one-cycle completion pulse to I/O
io_rdata  out  DATA_W  registered read data, valid while io_done=1
mem_en  out  1  memory access strobe (registered)
mem_we  out  1  memory write enable (registered)
mem_addr  out  ADDR_W  memory address (registered)
mem_wdata  out  DATA_W  memory write data (registered)
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, ACCESS, WAIT, DONE.
- Reset (sampled high at an edge) forces:
  - state=IDLE, owner=CPU, last_gnt=IO (so CPU wins the first tie), lat_cnt=0.
  - All done/mem_en/mem_we=0; mem_addr, mem_wdata, cpu_rdata, io_rdata=0.
  - Any in-flight transaction is abandoned, no done pulse issued.
- IDLE (cycle T):
  - Only cpu_req → grant CPU. Only io_req → grant IO.
  - Both requesting → grant the one != last_gnt.
  - On grant: latch owner, we, addr, wdata; last_gnt<=winner; go ACCESS. No request → stay IDLE.
- ACCESS (T+1):
  - mem_en=1; mem_we/mem_addr/mem_wdata come from the latched copies. Requester input changes after T are ignored.
  - Write → DONE. Read → WAIT with lat_cnt<=MEM_LAT.
- WAIT:
  - mem_en=0; lat_cnt decrements each cycle.
  - When lat_cnt==1: capture mem_rdata into the owner's rdata register, go DONE.
- DONE:
  - Owner's done=1 for exactly one cycle, then IDLE. Non-owner rdata is unchanged.
- Latency:
  - Write: done in T+2.
  - Read: done in T+2+MEM_LAT.
  - Minimum issue interval: write 3 cycles, read 3+MEM_LAT cycles.
- Handshake:
  - Requester must deassert req at the edge ending its done cycle, so IDLE never re-grants a stale request.
  - req deasserted before done is a protocol violation; the transaction still completes.
- Losing requester waits in IDLE/ACCESS/WAIT/DONE with no side effects. Round-robin bounds its wait to one transaction.
- mem_en is asserted only in ACCESS; never two accesses overlap.

Decomposition:
- Package mem_arb_pkg holds:
  - State encoding (IDLE=0, ACCESS=1, WAIT=2, DONE=3).
  - Requester IDs (REQ_CPU=0, REQ_IO=1).
  - Default ADDR_W/DATA_W.
- Sub-module mem_arb_rr_pick: pure combinational 2-way round-robin winner select (cpu_req, io_req, last_gnt → grant, winner). Reused later when a third requester (display/UART) is added.

Test Plan:
- CPU read alone, MEM_LAT=1, addr 0x0010, mem holds 0xBEEF:
  - mem_en=1 in T+1 with mem_addr=0x0010, mem_we=0.
  - cpu_done=1 in T+3 with cpu_rdata=0xBEEF.
  - cpu_stall=1 in T..T+2, 0 in T+3.
- IO write alone, addr 0x0200, data 0x1234:
  - mem_en=mem_we=1 in T+1 with 0x0200/0x1234.
  - io_done=1 in T+2; cpu_done stays 0.
- Both request in the same cycle after reset:
  - CPU granted first, then IO.
  - Then both again: CPU granted (last_gnt=IO).
  - Alternation holds over 8 back-to-back transactions.
- Requester changes addr/wdata from 0x0010 to 0x0FFF one cycle after grant: mem_addr stays 0x0010.
- MEM_LAT=4 read, mem_rdata=0x00AA valid only in cycle T+5: cpu_rdata=0x00AA with cpu_done in T+6.
- Reset asserted during WAIT:
  - Next cycle state=IDLE, mem_en=0, rdata=0, no done pulse.
  - Subsequent CPU request is granted normally.
